bird_datapath: RTL and testbench
================================

// Module: bird_datapath
// PURPOSE
//  Datapath and sprite renderer for the bird. It consumes the 4-bit state word from the bird control FSM.
//  Once per frame it erases the old sprite, applies vertical motion, and redraws the sprite onto the
//  160x120 VGA plot interface. It returns flag (bird too high) and touched (ground or pipe collision)
//  to the control FSM.
// PARAMETERS
//  X_POS      40   fixed sprite left column
//  Y_START    60   sprite top row after reset / START
//  BIRD_W     4    sprite width, pixels
//  BIRD_H     4    sprite height, pixels
//  Y_TOP      20   flag asserted when y_pos <= Y_TOP
//  Y_BOTTOM   116  touched set when y_pos >= Y_BOTTOM
//  RISE_STEP  2    rows moved up per frame while RAISING
//  FALL_STEP  1    rows moved down per frame while FALLING (initial step with gravity)
//  MAX_FALL   4    fall-step ceiling (gravity build only)
//  COLOUR     3'b110  sprite colour; erase colour is 3'b000
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  state      in   4  control state: START=0, RAISING=1, FALLING=2, STOP=3, DRAW=4, UPDATE=E, DEL=F
//  frame_tick in   1  one-cycle frame strobe
//  pipe_hit   in   1  collision pulse from the pipe block
//  flag       out  1  registered (y_pos <= Y_TOP)
//  touched    out  1  sticky collision flag
//  x          out  8  plot column
//  y          out  7  plot row
//  colour     out  3  plot colour
//  plot       out  1  VGA write enable
//  busy       out  1  high while an erase/move/draw sequence runs
// BEHAVIOUR
//  - Reset: y_pos=Y_START, mode=START, flag=0, touched=0, x=0, y=0, colour=0, plot=0, busy=0.
//    A reset mid-sequence aborts the sequence; plot=0 from the next cycle.
//  - Mode latch: every cycle with state in {0,1,2,3}, mode<=state. States 4/E/F and undefined codes
//    leave mode unchanged.
//  - START seen (state==0): y_pos<=Y_START and touched<=0 in the same cycle. This clear overrides any
//    set source.
//  - Renderer FSM: IDLE -> ERASE -> MOVE -> DRAW -> IDLE.
//  - IDLE: on frame_tick go to ERASE. frame_tick arriving while busy is dropped, not queued.
//  - ERASE: N=BIRD_W*BIRD_H cycles with plot=1 and colour=0. Raster order, column inner:
//    x=X_POS+col, y=y_pos+row.
//  - MOVE: 1 cycle with plot=0.
//      RAISING: y_pos<=max(y_pos-RISE_STEP,0).
//      FALLING: y_pos<=min(y_pos+step,120-BIRD_H).
//      START/STOP: y_pos held.
//    Arithmetic is done at 8 bits, then saturated to the 7-bit range.
//  - DRAW: N cycles, same order as ERASE, using the new y_pos and colour=COLOUR.
//  - Timing: tick at cycle 0; busy=1 for cycles 1..2N+1; first plot at cycle 1. flag and touched
//    reflect the new y_pos from the cycle after MOVE.
//  - touched set by pipe_hit (any cycle) or y_pos>=Y_BOTTOM. It stays set until START is seen.
//  - Outside ERASE/DRAW: plot=0; x, y, colour hold their last values.
// CONFIGURATION
//  - BIRD_GRAVITY_EN defined: fall step starts at FALL_STEP and grows by 1 after each FALLING MOVE, up
//    to MAX_FALL. It resets to FALL_STEP when mode is RAISING or START.
//  - Not defined: step is always FALL_STEP; MAX_FALL unused.
// TESTING
//  1. reset, state=0, one tick -> 16 plots colour 0 at x 40..43 / y 60..63, one idle cycle, then 16 plots
//     colour 3'b110 at the same pixels; busy high for exactly 33 cycles.
//  2. state=1 from y_pos=60, 20 ticks -> y_pos=20, flag=1 after the 20th MOVE; flag=0 before it.
//  3. state=2 from y_pos=110, 6 ticks -> y_pos=116, touched=1; touched stays 1 with state=3 until state=0.
//  4. pipe_hit pulse while y_pos=60 -> touched=1 next cycle; then state=0 -> touched=0, y_pos=60.
//  5. state=1 at y_pos=1, one tick -> y_pos=0 (saturation); a second tick 5 cycles after the first ->
//     ignored, one 33-cycle sequence only.
//  6. BIRD_GRAVITY_EN, state=2 from 60, 5 ticks -> y_pos 61,63,66,70,74; state=1 then state=2 -> step back to 1.

Source files
------------

// File: rtl/bird_datapath_if.sv
// bird_datapath_if: control/plot bus between the bird control FSM, the bird datapath and the VGA plotter
interface bird_datapath_if;
  logic [3:0] state;
  logic frame_tick;
  logic pipe_hit;
  logic flag;
  logic touched;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot;
  logic busy;
  modport master (output state, frame_tick, pipe_hit, input flag, touched, x, y, colour, plot, busy);
  modport slave (input state, frame_tick, pipe_hit, output flag, touched, x, y, colour, plot, busy);
endinterface

// File: rtl/bird_datapath.sv
// bird_datapath: per-frame erase/move/draw bird sprite renderer; define BIRD_GRAVITY_EN for an accelerating fall step
module bird_datapath #(
  parameter logic [7:0] X_POS = 8'd40,
  parameter logic [6:0] Y_START = 7'd60,
  parameter int BIRD_W = 4,
  parameter int BIRD_H = 4,
  parameter logic [6:0] Y_TOP = 7'd20,
  parameter logic [6:0] Y_BOTTOM = 7'd116,
  parameter logic [7:0] RISE_STEP = 8'd2,
  parameter logic [7:0] FALL_STEP = 8'd1,
`ifdef BIRD_GRAVITY_EN
  parameter logic [7:0] MAX_FALL = 8'd4,
`endif
  parameter logic [2:0] COLOUR = 3'b110
) (
  input logic clk,
  input logic reset,
  bird_datapath_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} st_t;
  localparam logic [7:0] W_LAST = 8'(BIRD_W - 1);
  localparam logic [7:0] H_LAST = 8'(BIRD_H - 1);
  localparam logic [6:0] Y_MAX = 7'(120 - BIRD_H);
  st_t st;
  logic [1:0] mode;
  logic [6:0] y_pos, y_nxt, y_mv;
  logic [7:0] col, row, ncol, nrow, step, fall;
  logic last, start;
`ifdef BIRD_GRAVITY_EN
  always_ff @(posedge clk)
    if (reset || mode == 2'd0 || mode == 2'd1) step <= FALL_STEP;
    else if (st == MOVE && mode == 2'd2 && step < MAX_FALL) step <= step + 8'd1;
`else
  assign step = FALL_STEP;
`endif
  always_comb begin
    start = bus.state == 4'd0;
    last = col == W_LAST && row == H_LAST;
    ncol = col == W_LAST ? 8'd0 : col + 8'd1;
    nrow = col == W_LAST ? row + 8'd1 : row;
    fall = {1'b0, y_pos} + step;
    y_mv = mode == 2'd1 ? ({1'b0, y_pos} < RISE_STEP ? 7'd0 : 7'({1'b0, y_pos} - RISE_STEP)) :
           mode == 2'd2 ? (fall > {1'b0, Y_MAX} ? Y_MAX : fall[6:0]) : y_pos;
    y_nxt = start ? Y_START : st == MOVE ? y_mv : y_pos;
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      mode <= 2'd0;
      y_pos <= Y_START;
      col <= 8'd0;
      row <= 8'd0;
      bus.flag <= 1'b0;
      bus.touched <= 1'b0;
      bus.x <= 8'd0;
      bus.y <= 7'd0;
      bus.colour <= 3'd0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      if (bus.state[3:2] == 2'b00) mode <= bus.state[1:0];
      y_pos <= y_nxt;
      bus.flag <= (y_nxt <= Y_TOP);
      bus.touched <= !start && (bus.touched || bus.pipe_hit || y_nxt >= Y_BOTTOM);
      case (st)
        IDLE: if (bus.frame_tick) begin
          st <= ERASE;
          col <= 8'd0;
          row <= 8'd0;
          bus.busy <= 1'b1;
          bus.plot <= 1'b1;
          bus.colour <= 3'd0;
          bus.x <= X_POS;
          bus.y <= y_pos;
        end
        MOVE: begin
          st <= DRAW;
          col <= 8'd0;
          row <= 8'd0;
          bus.plot <= 1'b1;
          bus.colour <= COLOUR;
          bus.x <= X_POS;
          bus.y <= y_nxt;
        end
        default: if (last) begin
          st <= st == ERASE ? MOVE : IDLE;
          bus.plot <= 1'b0;
          bus.busy <= st == ERASE;
        end else begin
          col <= ncol;
          row <= nrow;
          bus.x <= X_POS + ncol;
          bus.y <= 7'(y_pos + nrow);
        end
      endcase
    end
endmodule

// File: tb/tb_bird_datapath.sv
// tb_bird_datapath: directed and randomized frames checked against a per-frame behavioural bird model
module tb_bird_datapath;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;
  int fails = 0;
  int m_y = 60;
  int m_mode = 0;
  int m_step = 1;
  bit m_touched = 0;
  logic [3:0] codes [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hE, 4'hF};
  bird_datapath_if bus ();
  bird_datapath dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_state(input logic [3:0] s);
    bus.state = s;
    @(negedge clk);
    if (s < 4) m_mode = int'(s);
    if (s == 0) begin
      m_y = 60;
      m_touched = 0;
    end
    if (m_mode <= 1) m_step = 1;
  endtask
  task automatic pipe();
    bus.pipe_hit = 1'b1;
    @(negedge clk);
    bus.pipe_hit = 1'b0;
    if (bus.state != 4'd0) m_touched = 1;
    chk("pipe", {31'd0, bus.touched}, {31'd0, m_touched});
  endtask
  task automatic frame(input bit dbl);
    int y0, y1, j;
    bit f0;
    y0 = m_y;
    f0 = m_y <= 20;
    if (m_mode == 1) m_y = m_y < 2 ? 0 : m_y - 2;
    else if (m_mode == 2) begin
      m_y = m_y + m_step > 116 ? 116 : m_y + m_step;
`ifdef BIRD_GRAVITY_EN
      if (m_step < 4) m_step++;
`endif
    end
    if (m_y >= 116) m_touched = 1;
    y1 = m_y;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (dbl) bus.frame_tick = i == 4;
      if (i == 16) chk("move", {29'd0, bus.busy, bus.plot, bus.flag}, {29'd0, 2'b10, f0});
      else begin
        j = i < 16 ? i : i - 17;
        chk("pixel", {bus.busy, bus.plot, bus.colour, bus.x, bus.y},
            {2'b11, i < 16 ? 3'b000 : 3'b110, 8'(40 + j % 4), 7'((i < 16 ? y0 : y1) + j / 4)});
      end
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
    chk("done", {bus.busy, bus.plot, bus.flag, bus.touched}, {2'b00, m_y <= 20, m_touched});
  endtask
  initial begin
    reset = 1'b1;
    bus.state = 4'd0;
    bus.frame_tick = 1'b0;
    bus.pipe_hit = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", {bus.flag, bus.touched, bus.x, bus.y, bus.colour, bus.plot, bus.busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    frame(0);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid", {bus.flag, bus.touched, bus.x, bus.y, bus.colour, bus.plot, bus.busy}, 0);
    @(negedge clk);
    frame(0);
    set_state(4'd1);
    repeat (20) frame(0);
    chk("flag_top", {31'd0, bus.flag}, 32'd1);
    set_state(4'd2);
    for (int k = 0; k < 200 && m_y < 116; k++) frame(0);
    set_state(4'd3);
    repeat (2) frame(0);
    chk("touched_hold", {31'd0, bus.touched}, 32'd1);
    set_state(4'd0);
    chk("touched_clr", {31'd0, bus.touched}, 32'd0);
    frame(0);
    set_state(4'd3);
    pipe();
    set_state(4'd0);
    chk("pipe_clr", {31'd0, bus.touched}, 32'd0);
    frame(0);
    set_state(4'd1);
    for (int k = 0; k < 40 && m_y > 0; k++) frame(0);
    set_state(4'd2);
    frame(0);
    set_state(4'd1);
    frame(1);
    repeat (5) begin
      @(negedge clk);
      chk("tick_drop", {30'd0, bus.busy, bus.plot}, 32'd0);
    end
`ifdef BIRD_GRAVITY_EN
    set_state(4'd0);
    set_state(4'd2);
    repeat (5) frame(0);
    chk("grav_y", m_y, 32'd74);
    set_state(4'd1);
    set_state(4'd2);
    frame(0);
`endif
    for (int k = 0; k < 40; k++) begin
      set_state(codes[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) == 0) pipe();
      frame(0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
